countdown_timer: RTL



---
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer.sv | 76 +++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the controller drives start,
// stop, en, auto_reload and load_val; the timer returns count, busy and done.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, en, auto_reload, load_val,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, en, auto_reload, load_val,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle expiry pulse and optional
// auto-reload. Every output is a flop, so no input reaches an output
// combinationally. Priority each cycle: rst > stop > start > en.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;

  // Single-process FSM: state, count, the captured reload value/mode and the
  // registered busy/done outputs all update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // done is a pulse: low unless this cycle is an expiry
      done_q <= 1'b0;
      if (bus.stop) begin
        // abort keeps reload_q/mode_q so the captured settings survive
        state   <= IDLE;
        busy_q  <= 1'b0;
        count_q <= '0;
      end else if (bus.start) begin
        if (bus.load_val != '0) begin
          // load or restart; en is ignored in this cycle
          reload_q <= bus.load_val;
          mode_q   <= bus.auto_reload;
          count_q  <= bus.load_val;
          state    <= RUN;
          busy_q   <= 1'b1;
        end else begin
          // zero load expires immediately
          state   <= IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
          done_q  <= 1'b1;
        end
      end else if (state == RUN && bus.en) begin
        if (count_q == WIDTH'(1)) begin
          // 1 -> expiry instead of 0, so the counter never wraps
          done_q <= 1'b1;
          if (mode_q) begin
            count_q <= reload_q;
          end else begin
            count_q <= '0;
            state   <= IDLE;
            busy_q  <= 1'b0;
          end
        end else begin
          count_q <= count_q - WIDTH'(1);
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
